// File: rtl/dmux8way16_dist.sv
// dmux8way16_dist: one-to-eight stream demux with a one-entry register per channel and addressed or round-robin routing
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake; in_data is the offered word
//   sel, auto           : destination channel, or round-robin pointer when auto=1
//   out_valid/out_ready : per-channel handshake; out_data packs channel k at [WIDTH*k +: WIDTH]
//   ptr, xfer_count     : round-robin pointer and accepted-transfer count
module dmux8way16_dist #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         sel,
  input  logic               auto,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [2:0]         ptr,
  output logic [15:0]        xfer_count
);
  logic [7:0]       valid_q, valid_d, load;
  logic [WIDTH-1:0] data_q [8];
  logic [2:0]       ptr_q, ptr_d, tgt;
  logic [15:0]      cnt_q, cnt_d;
  logic             acc;
  always_comb begin
    tgt = auto ? ptr_q : sel;
    // a full target may still accept when it drains in the same cycle
    in_ready = ~valid_q[tgt] | out_ready[tgt];
    acc = in_valid & in_ready;
    for (int k = 0; k < 8; k++) begin
      load[k] = acc && (tgt == 3'(k));
      valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
    end
    ptr_d = ptr_q + 3'(acc & auto);
    cnt_d = cnt_q + 16'(acc);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < 8; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < 8; k++) if (load[k]) data_q[k] <= in_data;
    end
  end
  for (genvar g = 0; g < 8; g++) begin : g_out
    assign out_data[WIDTH*g +: WIDTH] = data_q[g];
  end
  assign out_valid = valid_q;
  assign ptr = ptr_q;
  assign xfer_count = cnt_q;
endmodule

// File: tb/tb_dmux8way16_dist.sv
// tb_dmux8way16_dist: scoreboard bench for dmux8way16_dist with a cycle model of channels, pointer and count
module tb_dmux8way16_dist;
  logic         clk = 0, rst_n = 0, in_valid = 0, in_ready, auto = 0;
  logic [15:0]  in_data = 0, xfer_count;
  logic [2:0]   sel = 0, ptr;
  logic [7:0]   out_valid, out_ready = 0;
  logic [127:0] out_data;
  dmux8way16_dist #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sel(sel), .auto(auto), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ptr(ptr), .xfer_count(xfer_count)
  );
  always #5 clk = ~clk;
  typedef struct {logic [2:0] ch; logic [15:0] d;} exp_t;
  exp_t        sb [$];
  logic [15:0] m_data [8];
  logic [7:0]  m_valid;
  logic [2:0]  m_ptr;
  logic [15:0] m_cnt;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_valid = 0;
    m_ptr = 0;
    m_cnt = 0;
    for (int k = 0; k < 8; k++) m_data[k] = 0;
    sb.delete();
  endtask
  task automatic step(input logic v, input logic [2:0] s, input logic a, input logic [7:0] ordy,
                      input logic [15:0] d, input bit full = 1);
    logic [2:0] t;
    logic       rdy, acc;
    exp_t       e;
    in_valid = v; sel = s; auto = a; out_ready = ordy; in_data = d;
    #1;
    t = a ? m_ptr : s;
    rdy = ~m_valid[t] | ordy[t];
    acc = v & rdy;
    if (full) check("in_ready", in_ready, rdy);
    if (acc) sb.push_back('{t, d});
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++)
      if (acc && t == 3'(k)) begin
        m_valid[k] = 1;
        m_data[k] = d;
      end else if (m_valid[k] && ordy[k]) m_valid[k] = 0;
    if (acc) begin
      m_ptr = m_ptr + 3'(a);
      m_cnt = m_cnt + 1;
      e = sb.pop_front();
      check("ch_data", out_data[16*e.ch +: 16], e.d);
      check("ch_valid", out_valid[e.ch], 1);
    end
    if (full) begin
      check("ptr", ptr, m_ptr);
      check("count", xfer_count, m_cnt);
      check("out_valid", out_valid, m_valid);
      for (int k = 0; k < 8; k++) check("hold_data", out_data[16*k +: 16], m_data[k]);
    end
  endtask
  logic [15:0] fill [8] = '{16'h3141, 16'h5926, 16'h5358, 16'h9793, 16'h2384, 16'h6264, 16'h3383, 16'h2795};
  initial begin
    model_reset();
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ptr", ptr, 0);
    check("rst_count", xfer_count, 0);
    check("rst_data", {31'b0, |out_data}, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) step(1, 3'(i), 0, 8'h00, fill[i]);
    check("fill_valid", out_valid, 8'hFF);
    check("fill_count", xfer_count, 8);
    check("fill_ptr", ptr, 0);
    step(1, 3, 0, 8'h00, 16'hAAAA);
    check("bp_ch3", out_data[48 +: 16], 16'h9793);
    step(1, 3, 0, 8'h08, 16'hAAAA);
    check("bp_ch3_new", out_data[48 +: 16], 16'hAAAA);
    check("bp_ch3_valid", out_valid[3], 1);
    step(0, 0, 0, 8'hFF, 0);
    for (int i = 1; i <= 10; i++) step(1, 0, 1, 8'hFF, 16'(i));
    check("rr_ptr", ptr, 2);
    check("rr_ch0", out_data[0 +: 16], 16'h0009);
    check("rr_ch1", out_data[16 +: 16], 16'h000A);
    step(0, 0, 1, 8'hFF, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h00, 16'h1000 + 16'(i));
    step(1, 5, 0, 8'h00, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 8'h00, 16'h6666);
      check("stall_ptr", ptr, 5);
      check("stall_ch6_empty", out_valid[6], 0);
    end
    step(1, 0, 1, 8'h20, 16'h7777);
    check("unstall_ptr", ptr, 6);
    check("unstall_ch5", out_data[80 +: 16], 16'h7777);
    step(1, 1, 0, 8'h0F, 16'h1234);
    step(1, 0, 1, 8'h81, 16'h4321);
    step(0, 2, 1, 8'hFF, 16'hDEAD);
    in_valid = 1; sel = 2; auto = 0; out_ready = 0; in_data = 16'hBEEF;
    #2 rst_n = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ptr", ptr, 0);
    check("mid_rst_count", xfer_count, 0);
    check("mid_rst_data", {31'b0, |out_data}, 0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_data", {31'b0, |out_data}, 0);
    #2 rst_n = 1;
    in_valid = 0;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 4, 0, 8'h00, 16'hCAFE);
    for (int i = 1; i < 65535; i++) step(1, 0, 1, 8'hFF, 16'(i), 0);
    check("wrap_pre", xfer_count, 16'hFFFF);
    step(1, 0, 1, 8'hFF, 16'h0BAD);
    check("wrap_post", xfer_count, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmux8way16_dist.md
DMUX8WAY16_DIST -- requirements
Module: dmux8way16_dist

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: the upstream word is present.
REQ-005 Port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-006 Port in_data, input, WIDTH bits: the upstream word.
REQ-007 Port sel, input, 3 bits: the destination channel when auto=0.
REQ-008 Port auto, input, 1 bit: when 1, ignore sel and use the round-robin pointer.
REQ-009 Port out_valid, output, 8 bits: bit k means channel k holds a word.
REQ-010 Port out_ready, input, 8 bits: bit k means the channel-k consumer takes the word.
REQ-011 Port out_data, output, 8*WIDTH bits: channel k occupies bits [WIDTH*k+WIDTH-1 : WIDTH*k].
REQ-012 Port ptr, output, 3 bits: the current round-robin pointer.
REQ-013 Port xfer_count, output, 16 bits: the count of accepted input transfers.

Function
REQ-014 Target channel t SHALL be ptr when auto=1, else sel; t is combinational from the current inputs.
REQ-015 Each channel SHALL hold a one-entry register consisting of a data word and a valid bit; out_valid and out_data SHALL be driven directly from these registers.
REQ-016 in_ready SHALL equal (~out_valid[t]) | out_ready[t]; in_ready is combinational and independent of in_valid.
REQ-017 Accept = in_valid & in_ready; on the next edge, channel t SHALL load in_data and set its valid bit (latency 1 cycle).
REQ-018 Drain of channel k = out_valid[k] & out_ready[k]; on the next edge, valid[k] SHALL clear unless channel k is loaded on the same edge.
REQ-019 Simultaneous drain and load on the same channel: valid stays 1 and data becomes the new word, with no bubble.
REQ-020 Loads and drains on different channels in the same cycle SHALL be independent.
REQ-021 While out_valid[k]=1 and it is not drained, out_data for channel k SHALL hold stable; non-target channels SHALL never change their data.
REQ-022 On accept with auto=1, ptr SHALL increment by 1 mod 8 (7 wraps to 0).
REQ-023 With auto=0, ptr SHALL hold; switching auto does not reset ptr.
REQ-024 When auto=1 and channel ptr is full and not draining, in_ready=0 and ptr SHALL hold; there is no skip-ahead to a free channel.
REQ-025 xfer_count SHALL increment by 1 on each accept and wrap 0xFFFF to 0x0000.
REQ-026 When in_valid=0, the block SHALL perform no load, no ptr change, and no count change.

Reset
REQ-027 On rst_n low, asynchronously: out_valid=8'h00, out_data=0, ptr=3'd0, xfer_count=16'h0000.
REQ-028 Reset SHALL take effect mid-transfer; any word accepted in the same cycle as the reset assertion is discarded.
REQ-029 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-030 Addressed fill: auto=0, out_ready=0, send 3141,5926,5358,9793,2384,6264,3383,2795 (hex) with sel=0..7 -> one cycle later each out_valid bit k=1 with channel k = listed word k; xfer_count=8; ptr=0.
REQ-031 Backpressure: all channels full, out_ready=0, in_valid=1, sel=3 -> in_ready=0 and channel 3 stays 9793; then raise out_ready[3] with in_data=AAAA -> in_ready=1 and next cycle channel 3=AAAA, out_valid[3]=1.
REQ-032 Round-robin wrap: auto=1, out_ready=8'hFF, 10 consecutive accepts of 0001..000A -> ptr sequence 0..7,0,1, ending ptr=2; channel 0=0009, channel 1=000A.
REQ-033 Auto stall: auto=1, ptr=5, channel 5 full, out_ready[5]=0, channel 6 empty -> in_ready=0 and ptr stays 5 until out_ready[5]=1.
REQ-034 Reset mid-operation: after mixed traffic, pulse rst_n low between clock edges -> outputs are immediately out_valid=00, ptr=0, xfer_count=0000, all data 0; a word offered during reset is not stored.
REQ-035 Counter wrap: preload via 65535 accepts, then one more -> xfer_count goes FFFF to 0000.
